// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared state encoding and constants for the MD5 padding controller
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_FEED,
    ST_WAIT_DONE,
    ST_RESULT,
    ST_DRAIN
  } md5_state_t;

  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  // Message words that fit ahead of the 0x80 marker and the length words
  localparam int BUF_WORDS = 14;
  localparam logic [6:0] MAX_MSG_BYTES = 7'd55;
  localparam logic [3:0] LEN_WORD_LO = 4'd14;
  localparam logic [3:0] LEN_WORD_HI = 4'd15;

endpackage

// File: rtl/md5_pad_ctrl_if.sv
// rtl/md5_pad_ctrl_if.sv - upstream, core and result signal bundle of md5_pad_ctrl
interface md5_pad_ctrl_if;

  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [1:0]   s_bytes;

  logic         core_rdy;
  logic [31:0]  core_msg;
  logic         core_write_en;
  logic         core_done;
  logic [31:0]  core_a;
  logic [31:0]  core_b;
  logic [31:0]  core_c;
  logic [31:0]  core_d;

  logic         d_valid;
  logic         d_ready;
  logic [127:0] digest;
  logic         err;

  modport slave (
    input  s_valid, s_data, s_last, s_bytes,
    input  core_rdy, core_done, core_a, core_b, core_c, core_d,
    input  d_ready,
    output s_ready, core_msg, core_write_en, d_valid, digest, err
  );

  modport master (
    output s_valid, s_data, s_last, s_bytes,
    output core_rdy, core_done, core_a, core_b, core_c, core_d,
    output d_ready,
    input  s_ready, core_msg, core_write_en, d_valid, digest, err
  );

endinterface

// File: rtl/md5_block_pad.sv
// rtl/md5_block_pad.sv - combinational MD5 single-block padding, one 32-bit word per index
module md5_block_pad
  import md5_pkg::*;
(
  input  logic [BUF_WORDS*32-1:0] blk,
  input  logic [6:0]              len,
  input  logic [3:0]              idx,
  output logic [31:0]             word
);

  logic [3:0]  widx;
  logic [31:0] raw;
  logic [6:0]  k;

  assign widx = (idx < LEN_WORD_LO) ? idx : 4'd0;
  assign raw  = blk[32*widx +: 32];

  always_comb begin
    word = '0;
    k    = '0;
    if (idx == LEN_WORD_LO) begin
      word = {22'd0, len, 3'd0};
    end else if (idx == LEN_WORD_HI) begin
      word = '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        k = {1'b0, idx, 2'(j)};
        if (k < len)
          word[8*j +: 8] = raw[8*j +: 8];
        else if (k == len)
          word[8*j +: 8] = 8'h80;
        else
          word[8*j +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/md5_pad_ctrl.sv
// rtl/md5_pad_ctrl.sv - collects a short message, feeds one padded MD5 block to the core, returns digest
// Define MD5_PAD_CTRL_TIMEOUT_EN to bound the wait for core_done by TIMEOUT_CYC cycles.
module md5_pad_ctrl
  import md5_pkg::*;
#(
  parameter int TIMEOUT_CYC = 128
) (
  input logic          clk,
  input logic          rst_n,
  md5_pad_ctrl_if.slave bus
);

  md5_state_t              state_q, state_d;
  logic [BUF_WORDS*32-1:0] blk_q;
  logic [6:0]              len_q;
  logic [3:0]              wcnt_q;
  logic [3:0]              feed_q;
  logic [127:0]            digest_q;
  logic                    err_q;

  logic        beat;
  logic        collecting;
  logic [2:0]  beat_bytes;
  logic [6:0]  len_sum;
  logic        overflow;
  logic [3:0]  widx;
  logic        fin_ok;
  logic        fin_err;
  logic        timeout;
  logic [31:0] pad_word;

  assign collecting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign beat       = bus.s_valid && bus.s_ready;
  assign beat_bytes = (bus.s_last && bus.s_bytes != 2'd0) ? {1'b0, bus.s_bytes} : 3'd4;
  assign len_sum    = ((state_q == ST_IDLE) ? 7'd0 : len_q) + {4'd0, beat_bytes};
  assign overflow   = len_sum > MAX_MSG_BYTES;
  assign widx       = (state_q == ST_IDLE) ? 4'd0 : wcnt_q;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

`ifdef MD5_PAD_CTRL_TIMEOUT_EN
  logic [31:0] to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_q <= '0;
    else if (state_q == ST_WAIT_DONE)
      to_q <= to_q + 32'd1;
    else
      to_q <= '0;
  end

  assign timeout = (state_q == ST_WAIT_DONE) && (to_q == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (beat)
          state_d = bus.s_last ? ST_ISSUE : ST_COLLECT;
      end
      ST_COLLECT: begin
        // An overflow on the closing beat has nothing left to drain
        if (beat) begin
          if (overflow) begin
            if (bus.s_last) begin
              state_d = ST_RESULT;
              fin_err = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else if (bus.s_last) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.core_rdy)
          state_d = ST_FEED;
      end
      ST_FEED: begin
        if (feed_q == LEN_WORD_HI)
          state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.core_done) begin
          state_d = ST_RESULT;
          fin_ok  = 1'b1;
        end else if (timeout) begin
          state_d = ST_RESULT;
          fin_err = 1'b1;
        end
      end
      ST_RESULT: begin
        if (bus.d_ready)
          state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (beat && bus.s_last) begin
          state_d = ST_RESULT;
          fin_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q    <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      feed_q   <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (beat && collecting && !overflow) begin
        blk_q[32*widx +: 32] <= bus.s_data;
        wcnt_q               <= widx + 4'd1;
        len_q                <= len_sum;
      end
      // Wraps back to zero after W15, ready for the next block
      if (state_q == ST_FEED)
        feed_q <= feed_q + 4'd1;
      if (fin_ok) begin
        digest_q <= {bus.core_d, bus.core_c, bus.core_b, bus.core_a};
        err_q    <= 1'b0;
      end else if (fin_err) begin
        digest_q <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  md5_block_pad u_pad (
    .blk  (blk_q),
    .len  (len_q),
    .idx  (feed_q),
    .word (pad_word)
  );

  assign bus.s_ready       = collecting || (state_q == ST_DRAIN);
  assign bus.core_write_en = (state_q == ST_FEED);
  assign bus.core_msg      = (state_q == ST_FEED) ? pad_word : 32'd0;
  assign bus.d_valid       = (state_q == ST_RESULT);
  assign bus.digest        = digest_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_md5_pad_ctrl.sv
// tb/tb_md5_pad_ctrl.sv - self-checking bench for md5_pad_ctrl with a behavioural core model
// The timeout case runs when MD5_PAD_CTRL_TIMEOUT_EN is defined.
module tb_md5_pad_ctrl;

  localparam int TO = 40;
  localparam logic [127:0] ABC_DIG = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md5_pad_ctrl_if bus ();

  md5_pad_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int           len;
    logic [511:0] msg;
    logic         err;
    logic [31:0]  a, b, c, d;
  } vec_t;

  typedef struct {
    logic         err;
    logic [127:0] digest;
  } res_t;

  vec_t  tbl[7];
  res_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_n = 0;
  int    we_total = 0;
  int    cap_n = 0;
  int    core_lat = 2;
  logic  hold_done = 1'b0;
  logic [31:0] cap[16];
  logic [31:0] blk_last[16];
  logic [31:0] exp_w[16];
  logic [31:0] rsp_a, rsp_b, rsp_c, rsp_d;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent byte-array formulation of the single-block padding
  task automatic build_exp(input int len, input logic [511:0] msg);
    logic [7:0] b[64];
    for (int k = 0; k < 64; k++) b[k] = (k < len) ? msg[8*k +: 8] : 8'h00;
    b[len] = 8'h80;
    {b[59], b[58], b[57], b[56]} = 32'(len * 8);
    for (int i = 0; i < 16; i++) exp_w[i] = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endtask

  initial begin : core_model
    int   lat;
    logic pending;
    lat = 0;
    pending = 1'b0;
    bus.core_done = 1'b0;
    bus.core_a = '0;
    bus.core_b = '0;
    bus.core_c = '0;
    bus.core_d = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        cap_n = 0;
        pending = 1'b0;
        bus.core_done = 1'b0;
      end else begin
        bus.core_done = 1'b0;
        if (pending) begin
          if (lat == 0) begin
            bus.core_done = 1'b1;
            bus.core_a = rsp_a;
            bus.core_b = rsp_b;
            bus.core_c = rsp_c;
            bus.core_d = rsp_d;
            pending = 1'b0;
          end else begin
            lat--;
          end
        end
        if (bus.core_write_en) begin
          cap[cap_n] = bus.core_msg;
          cap_n++;
          we_total++;
          if (cap_n == 16) begin
            for (int i = 0; i < 16; i++) begin
              blk_last[i] = cap[i];
              chk($sformatf("block_w%0d", i), cap[i], exp_w[i]);
            end
            cap_n = 0;
            pending = !hold_done;
            lat = core_lat;
          end
        end
      end
    end
  end

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.d_valid && bus.d_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got digest %h err %b, required no result", bus.digest, bus.err);
        end else begin
          e = sb_q.pop_front();
          chk("result_digest", bus.digest, e.digest);
          chk("result_err", bus.err, e.err);
        end
        done_n++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_msg(input int len, input logic [511:0] msg);
    int nb;
    int w;
    nb = (len + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = msg[32*i +: 32];
      bus.s_last  = (i == nb - 1);
      bus.s_bytes = 2'(len % 4);
      w = 0;
      while (!bus.s_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) begin
        checks++;
        errors++;
        $display("FAIL s_ready_wait: got s_ready 0 for %0d cycles, required 1", w);
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_result(input int target, input string name);
    int w;
    w = 0;
    while (done_n < target && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (done_n < target) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: got %0d results, required %0d", name, done_n, target);
    end
  endtask

  task automatic load_vec(input vec_t v);
    res_t e;
    build_exp(v.len, v.msg);
    rsp_a = v.a;
    rsp_b = v.b;
    rsp_c = v.c;
    rsp_d = v.d;
    e.err = v.err;
    e.digest = v.err ? 128'd0 : {v.d, v.c, v.b, v.a};
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int start_n;
    int we0;
    load_vec(v);
    start_n = done_n;
    we0 = we_total;
    send_msg(v.len, v.msg);
    wait_result(start_n + 1, name);
    if (v.err) chk({name, "_no_write_en"}, 128'(we_total), 128'(we0));
  endtask

  initial begin : main
    logic [511:0] m;
    int n, w, start_n, we0;
    int bad_v, bad_d, bad_r;

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.s_bytes  = '0;
    bus.core_rdy = 1'b1;
    bus.d_ready  = 1'b1;

    tbl[0] = '{3, 512'h636261, 1'b0, 32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};
    tbl[1] = '{1, 512'h61, 1'b0, 32'hb975c10c, 32'ha8b6f1c0, 32'he299c331, 32'h61267769};
    m = '0;
    for (int k = 0; k < 55; k++) m[8*k +: 8] = 8'(k + 1);
    m[8*55 +: 8] = 8'hee;
    tbl[2] = '{55, m, 1'b0, 32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    for (int k = 0; k < 64; k++) m[8*k +: 8] = 8'(8'hc3 ^ k);
    tbl[3] = '{56, m, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4};
    tbl[4] = '{60, m, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8};
    tbl[5] = '{4, 512'hdeadbeef, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom;
    tbl[6] = '{10, m, 1'b0, $urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", 128'(bus.s_ready), 128'd1);
    chk("rst_write_en", 128'(bus.core_write_en), 128'd0);
    chk("rst_core_msg", 128'(bus.core_msg), 128'd0);
    chk("rst_d_valid", 128'(bus.d_valid), 128'd0);
    chk("rst_err", 128'(bus.err), 128'd0);
    chk("rst_digest", bus.digest, 128'd0);
    rst_n = 1'b1;
    we0 = we_total;
    repeat (3) @(negedge clk);
    chk("release_no_write_en", 128'(we_total), 128'(we0));

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      case (i)
        0: begin
          chk("abc_w0", 128'(blk_last[0]), 128'h80636261);
          chk("abc_w14", 128'(blk_last[14]), 128'h18);
        end
        1: begin
          chk("a_w0", 128'(blk_last[0]), 128'h00008061);
          chk("a_w14", 128'(blk_last[14]), 128'h8);
        end
        2: begin
          chk("b55_w13_byte3", 128'(blk_last[13][31:24]), 128'h80);
          chk("b55_w14", 128'(blk_last[14]), 128'h1b8);
        end
        default: ;
      endcase
    end

    // Core not ready: the block must wait in ISSUE
    bus.core_rdy = 1'b0;
    load_vec(tbl[1]);
    start_n = done_n;
    we0 = we_total;
    send_msg(tbl[1].len, tbl[1].msg);
    repeat (10) @(negedge clk);
    chk("rdy_hold_no_write_en", 128'(we_total), 128'(we0));
    chk("rdy_hold_s_ready", 128'(bus.s_ready), 128'd0);
    bus.core_rdy = 1'b1;
    wait_result(start_n + 1, "rdy_hold");

    // Result backpressure
    bus.d_ready = 1'b0;
    load_vec(tbl[0]);
    start_n = done_n;
    send_msg(tbl[0].len, tbl[0].msg);
    w = 0;
    while (!bus.d_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("bp_d_valid_seen", 128'(bus.d_valid), 128'd1);
    bad_v = 0;
    bad_d = 0;
    bad_r = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.d_valid) bad_v++;
      if (bus.digest !== ABC_DIG) bad_d++;
      if (bus.s_ready) bad_r++;
    end
    chk("bp_d_valid_drops", 128'(bad_v), 128'd0);
    chk("bp_digest_changes", 128'(bad_d), 128'd0);
    chk("bp_s_ready_high", 128'(bad_r), 128'd0);
    bus.d_ready = 1'b1;
    wait_result(start_n + 1, "bp");
    @(negedge clk);
    chk("bp_back_idle", 128'(bus.s_ready), 128'd1);

    // Reset while FEED presents word 7
    build_exp(tbl[0].len, tbl[0].msg);
    send_msg(tbl[0].len, tbl[0].msg);
    n = 0;
    w = 0;
    while (n < 8 && w < 200) begin
      @(negedge clk);
      w++;
      if (bus.core_write_en) n++;
    end
    chk("feed_word7_reached", 128'(n), 128'd8);
    chk("feed_word7_value", 128'(bus.core_msg), 128'(exp_w[7]));
    rst_n = 1'b0;
    #1;
    chk("midfeed_write_en", 128'(bus.core_write_en), 128'd0);
    chk("midfeed_core_msg", 128'(bus.core_msg), 128'd0);
    chk("midfeed_s_ready", 128'(bus.s_ready), 128'd1);
    chk("midfeed_digest", bus.digest, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we0 = we_total;
    repeat (3) @(negedge clk);
    chk("midfeed_release_no_write_en", 128'(we_total), 128'(we0));
    chk("midfeed_release_d_valid", 128'(bus.d_valid), 128'd0);
    run_vec(tbl[0], "abc_after_reset");

`ifdef MD5_PAD_CTRL_TIMEOUT_EN
    hold_done = 1'b1;
    bus.d_ready = 1'b0;
    tbl[1].err = 1'b1;
    load_vec(tbl[1]);
    start_n = done_n;
    send_msg(tbl[1].len, tbl[1].msg);
    n = 0;
    w = 0;
    while (n < 16 && w < 200) begin
      @(negedge clk);
      w++;
      if (bus.core_write_en) n++;
    end
    n = 0;
    while (!bus.d_valid && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 128'(n), 128'(TO + 1));
    chk("timeout_err", 128'(bus.err), 128'd1);
    bus.d_ready = 1'b1;
    hold_done = 1'b0;
    wait_result(start_n + 1, "timeout");
    tbl[1].err = 1'b0;
    run_vec(tbl[1], "a_after_timeout");
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
